// File: rtl/pipe_dmem_bus_if.sv
// pipe_dmem_bus_if
// Data-memory port between the CPU MEM stage and the data-side responder.
//   MemWrite  : store strobe (master -> slave)
//   addr      : byte address, the ALU result (master -> slave)
//   writedata : store data (master -> slave)
//   readdata  : load data, combinational from addr (slave -> master)
interface pipe_dmem_bus_if;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output MemWrite,
        output addr,
        output writedata,
        input  readdata
    );

    modport slave (
        input  MemWrite,
        input  addr,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pipe_dmem_bus.sv
// pipe_dmem_bus
// Data-side memory responder for the pipelined CPU. Each word-aligned access
// is routed either to a word-addressed data RAM or to a small peripheral
// window: LED register, synchronized switches, a compare timer with
// interrupt, and a counter of RAM writes.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset (RAM contents are kept)
//   bus       : slave side of pipe_dmem_bus_if (MemWrite/addr/writedata/readdata)
//   sw_in     : asynchronous switch inputs
//   led_out   : LED register
//   timer_irq : timer interrupt request (level, equals PEND)
module pipe_dmem_bus #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [15:0] MMIO_TAG    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_dmem_bus_if.slave        bus,
    input  logic [15:0]           sw_in,
    output logic [15:0]           led_out,
    output logic                  timer_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SWITCH = 8'h04;
    localparam logic [7:0] OFF_TCOUNT = 8'h08;
    localparam logic [7:0] OFF_TCMP   = 8'h0C;
    localparam logic [7:0] OFF_TCTRL  = 8'h10;
    localparam logic [7:0] OFF_WRCNT  = 8'h14;

    // Data RAM; deliberately outside the reset domain.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [15:0] led_q,    led_d;
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;
    logic [31:0] tcount_q, tcount_d;
    logic [31:0] tcmp_q,   tcmp_d;
    logic        en_q,     en_d;
    logic        auto_q,   auto_d;
    logic        pend_q,   pend_d;
    logic [31:0] wrcnt_q,  wrcnt_d;

    logic          is_mmio_s;
    logic [AW-1:0] ram_idx_s;
    logic [7:0]    off_s;
    logic          ram_we_s;
    logic          mmio_we_s;
    logic          match_s;
    logic [31:0]   readdata_s;

    // Address decode and write qualification; no write is performed in reset.
    always_comb begin
        is_mmio_s = (bus.addr[31:16] == MMIO_TAG);
        ram_idx_s = bus.addr[AW+1:2];
        off_s     = bus.addr[7:0];
        ram_we_s  = bus.MemWrite & ~rst & ~is_mmio_s;
        mmio_we_s = bus.MemWrite & ~rst &  is_mmio_s;
    end

    // Next-state logic for the peripheral registers and the timer.
    always_comb begin
        led_d    = led_q;
        tcount_d = tcount_q;
        tcmp_d   = tcmp_q;
        en_d     = en_q;
        auto_d   = auto_q;
        pend_d   = pend_q;
        wrcnt_d  = wrcnt_q;

        // Match only counts while the timer is enabled with the pre-edge EN.
        match_s = en_q & (tcount_q == tcmp_q);

        if (en_q) begin
            if (match_s) begin
                tcount_d = auto_q ? 32'd0 : (tcount_q + 32'd1);
            end else begin
                tcount_d = tcount_q + 32'd1;
            end
        end else begin
            tcount_d = tcount_q;
        end

        if (ram_we_s) begin
            wrcnt_d = wrcnt_q + 32'd1;
        end else begin
            wrcnt_d = wrcnt_q;
        end

        if (mmio_we_s) begin
            case (off_s)
                OFF_LED:    led_d    = bus.writedata[15:0];
                OFF_TCOUNT: tcount_d = bus.writedata;   // CPU write beats count/reload
                OFF_TCMP:   tcmp_d   = bus.writedata;
                OFF_TCTRL: begin
                    en_d   = bus.writedata[0];
                    auto_d = bus.writedata[1];
                    if (bus.writedata[2]) begin
                        pend_d = 1'b0;
                    end else begin
                        pend_d = pend_q;
                    end
                end
                default: begin
                    led_d = led_q;  // read-only and unmapped offsets ignore writes
                end
            endcase
        end else begin
            led_d = led_q;
        end

        // A match sets PEND even when the same edge carries a write-1-to-clear.
        if (match_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // Peripheral, timer and synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= 16'd0;
            sync1_q  <= 16'd0;
            sync2_q  <= 16'd0;
            tcount_q <= 32'd0;
            tcmp_q   <= 32'hFFFF_FFFF;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            pend_q   <= 1'b0;
            wrcnt_q  <= 32'd0;
        end else begin
            led_q    <= led_d;
            sync1_q  <= sw_in;
            sync2_q  <= sync1_q;
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            pend_q   <= pend_d;
            wrcnt_q  <= wrcnt_d;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[ram_idx_s] <= bus.writedata;
        end
    end

    // Combinational load path; a same-cycle store is not yet visible here.
    always_comb begin
        readdata_s = 32'd0;
        if (is_mmio_s) begin
            case (off_s)
                OFF_LED:    readdata_s = {16'd0, led_q};
                OFF_SWITCH: readdata_s = {16'd0, sync2_q};
                OFF_TCOUNT: readdata_s = tcount_q;
                OFF_TCMP:   readdata_s = tcmp_q;
                OFF_TCTRL:  readdata_s = {29'd0, pend_q, auto_q, en_q};
                OFF_WRCNT:  readdata_s = wrcnt_q;
                default:    readdata_s = 32'd0;
            endcase
        end else begin
            readdata_s = mem_q[ram_idx_s];
        end
    end

    assign bus.readdata = readdata_s;
    assign led_out      = led_q;
    assign timer_irq    = pend_q;

endmodule

// File: tb/tb_pipe_dmem_bus.sv
module tb_pipe_dmem_bus;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_SWITCH = 32'hFFFF_0004;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_000C;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_0010;
    localparam logic [31:0] A_WRCNT  = 32'hFFFF_0014;
    localparam logic [31:0] A_UNMAP  = 32'hFFFF_0020;

    logic        clk;
    logic        rst;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        timer_irq;

    pipe_dmem_bus_if bus_if();

    pipe_dmem_bus #(.DEPTH_WORDS(1024), .MMIO_TAG(16'hFFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q [$];
    logic [31:0] exp_v;

    // Drive one store; called just after a falling edge, returns at the next one.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.MemWrite  = 1'b1;
        bus_if.addr      = a;
        bus_if.writedata = d;
        @(negedge clk);
        bus_if.MemWrite  = 1'b0;
    endtask

    // Present a load address and queue the value it must return.
    task automatic push_load(input logic [31:0] a, input logic [31:0] e);
        bus_if.MemWrite = 1'b0;
        bus_if.addr     = a;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] addrs [7];
        logic [31:0] exps  [7];
        addrs = '{A_LED, A_SWITCH, A_TCOUNT, A_TCMP, A_TCTRL, A_WRCNT, A_UNMAP};
        exps  = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            push_load(addrs[i], exps[i]);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL reset_read[%0d] addr=%h got=%h exp=%h", i, addrs[i], bus_if.readdata, exp_v);
            end
        end
        sb_q.push_back(32'd0);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({16'd0, led_out} !== exp_v || {31'd0, timer_irq} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_outputs led=%h irq=%b exp=0", led_out, timer_irq);
        end
    endtask

    task automatic test_ram();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        addrs = '{32'h0000_0010, 32'h0000_0013, A_WRCNT};
        exps  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1};
        for (int i = 0; i < 3; i++) begin
            push_load(addrs[i], exps[i]);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL ram_load[%0d] addr=%h got=%h exp=%h", i, addrs[i], bus_if.readdata, exp_v);
            end
        end
    endtask

    task automatic test_ram_wrap();
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        // Same-cycle load of the store address still sees the old word.
        bus_if.MemWrite  = 1'b1;
        bus_if.addr      = 32'h0000_1010;
        bus_if.writedata = 32'h1234_5678;
        sb_q.push_back(32'hDEAD_BEEF);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (bus_if.readdata !== exp_v) begin
            n_fail++;
            $display("FAIL ram_same_cycle got=%h exp=%h", bus_if.readdata, exp_v);
        end
        @(negedge clk);
        bus_if.MemWrite = 1'b0;
        bus_write(32'h0000_0020, 32'h1111_1111);
        addrs = '{32'h0000_0010, 32'h0000_1010, 32'h0000_0020, A_WRCNT};
        exps  = '{32'h1234_5678, 32'h1234_5678, 32'h1111_1111, 32'd3};
        for (int i = 0; i < 4; i++) begin
            push_load(addrs[i], exps[i]);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL ram_wrap[%0d] addr=%h got=%h exp=%h", i, addrs[i], bus_if.readdata, exp_v);
            end
        end
    endtask

    task automatic test_led_switch();
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        bus_write(A_LED, 32'h0001_A5A5);
        sb_q.push_back(32'h0000_A5A5);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({16'd0, led_out} !== exp_v) begin
            n_fail++;
            $display("FAIL led_out got=%h exp=%h", led_out, exp_v[15:0]);
        end
        // Writes to unmapped and read-only offsets must not change anything.
        bus_write(A_UNMAP, 32'hFFFF_FFFF);
        bus_write(A_WRCNT, 32'h0000_0055);
        bus_write(A_SWITCH, 32'h0000_1234);
        addrs = '{A_LED, A_UNMAP, A_WRCNT, A_SWITCH};
        exps  = '{32'h0000_A5A5, 32'd0, 32'd3, 32'd0};
        for (int i = 0; i < 4; i++) begin
            push_load(addrs[i], exps[i]);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL mmio_read[%0d] addr=%h got=%h exp=%h", i, addrs[i], bus_if.readdata, exp_v);
            end
        end
        // Switch change becomes visible after two rising edges.
        sw_in = 16'h00FF;
        for (int e = 0; e < 3; e++) begin
            if (e > 0) @(negedge clk);
            push_load(A_SWITCH, (e == 2) ? 32'h0000_00FF : 32'd0);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL switch_sync edges=%0d got=%h exp=%h", e, bus_if.readdata, exp_v);
            end
        end
    endtask

    task automatic test_timer_oneshot();
        bus_write(A_TCMP, 32'd5);
        bus_write(A_TCOUNT, 32'd0);
        bus_write(A_TCTRL, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            sb_q.push_back((i == 6) ? 32'd1 : 32'd0);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({31'd0, timer_irq} !== exp_v) begin
                n_fail++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%0d", i, timer_irq, exp_v);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            push_load(A_TCOUNT, 32'd6 + k);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL oneshot_tcount k=%0d got=%h exp=%h", k, bus_if.readdata, exp_v);
            end
        end
        bus_write(A_TCTRL, 32'h5);
        push_load(A_TCTRL, 32'h1);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (bus_if.readdata !== exp_v || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_clear tctrl=%h irq=%b exp_tctrl=%h exp_irq=0", bus_if.readdata, timer_irq, exp_v);
        end
    endtask

    task automatic test_auto_collision();
        logic [31:0] m_cnt;
        logic        m_pend;
        bus_write(A_TCTRL, 32'h4);
        bus_write(A_TCOUNT, 32'd0);
        bus_write(A_TCMP, 32'd3);
        bus_write(A_TCTRL, 32'h3);
        m_cnt  = 32'd0;
        m_pend = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (m_cnt == 32'd3) begin
                m_cnt  = 32'd0;
                m_pend = 1'b1;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
            push_load(A_TCOUNT, m_cnt);
            sb_q.push_back({31'd0, m_pend});
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL auto_tcount edge=%0d got=%h exp=%h", k, bus_if.readdata, exp_v);
            end
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({31'd0, timer_irq} !== exp_v) begin
                n_fail++;
                $display("FAIL auto_irq edge=%0d got=%b exp=%0d", k, timer_irq, exp_v);
            end
        end
        // Count is 0 with PEND set; three edges bring it to the match value.
        repeat (3) @(negedge clk);
        bus_write(A_TCTRL, 32'h7);
        push_load(A_TCTRL, 32'h7);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (bus_if.readdata !== exp_v) begin
            n_fail++;
            $display("FAIL collide_pend_set tctrl=%h exp=%h", bus_if.readdata, exp_v);
        end
        bus_write(A_TCTRL, 32'h7);
        push_load(A_TCTRL, 32'h3);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (bus_if.readdata !== exp_v) begin
            n_fail++;
            $display("FAIL pend_w1c tctrl=%h exp=%h", bus_if.readdata, exp_v);
        end
        // Count is 1; two edges reach 3, then a TCOUNT write lands on the match edge.
        repeat (2) @(negedge clk);
        bus_write(A_TCOUNT, 32'd100);
        push_load(A_TCOUNT, 32'd100);
        sb_q.push_back(32'd1);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (bus_if.readdata !== exp_v) begin
            n_fail++;
            $display("FAIL collide_tcount got=%h exp=%h", bus_if.readdata, exp_v);
        end
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({31'd0, timer_irq} !== exp_v) begin
            n_fail++;
            $display("FAIL collide_irq got=%b exp=%0d", timer_irq, exp_v);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        sb_q.push_back(32'd0);
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({16'd0, led_out} !== exp_v || {31'd0, timer_irq} !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_outputs led=%h irq=%b exp=0", led_out, timer_irq);
        end
        addrs = '{A_TCOUNT, A_WRCNT, A_TCMP, A_TCTRL};
        exps  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            push_load(addrs[i], exps[i]);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_read[%0d] addr=%h got=%h exp=%h", i, addrs[i], bus_if.readdata, exp_v);
            end
        end
        // A store attempted while reset is held must be dropped.
        bus_if.MemWrite  = 1'b1;
        bus_if.addr      = 32'h0000_0020;
        bus_if.writedata = 32'h0BAD_0BAD;
        @(negedge clk);
        bus_if.MemWrite = 1'b0;
        rst = 1'b0;
        addrs = '{32'h0000_0010, 32'h0000_0020, A_WRCNT, A_LED};
        exps  = '{32'h1234_5678, 32'h1111_1111, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            push_load(addrs[i], exps[i]);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (bus_if.readdata !== exp_v) begin
                n_fail++;
                $display("FAIL postrst_read[%0d] addr=%h got=%h exp=%h", i, addrs[i], bus_if.readdata, exp_v);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        sw_in            = 16'h0000;
        bus_if.MemWrite  = 1'b0;
        bus_if.addr      = 32'd0;
        bus_if.writedata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        @(negedge clk);
        test_ram();
        @(negedge clk);
        test_ram_wrap();
        @(negedge clk);
        test_led_switch();
        @(negedge clk);
        test_timer_oneshot();
        @(negedge clk);
        test_auto_collision();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_dmem_bus.md
# pipe_dmem_bus

Data-side memory responder for the pipelined CPU. It sits on the CPU's MEM-stage port, which drives `MemWrite`, the ALU result as address and the store data, and which expects `readdata` back in the same cycle. The block decodes each address to either a word-addressed data RAM or a memory-mapped peripheral window. The window holds an LED output register, a synchronized switch input, a programmable timer with interrupt, and a RAM-write counter.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit RAM words; power of two.
- `MMIO_TAG`, 16'hFFFF: value of `addr[31:16]` that selects the peripheral window.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `MemWrite`  in  1  store strobe from the EX/MEM register.
- `addr`  in  32  byte address (the CPU's ALU output).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; combinational from `addr`.
- `sw_in`  in  16  asynchronous switch inputs.
- `led_out`  out  16  LED register.
- `timer_irq`  out  1  timer interrupt request, level.

## Operation
- **Decode.** `addr[31:16]==MMIO_TAG` selects the peripheral window; any other value selects RAM. `addr[1:0]` is ignored in both regions, so all accesses are whole-word.
- **RAM.**
  - Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher bits outside the tag are ignored, so accesses wrap modulo DEPTH_WORDS.
  - Reads are asynchronous. Writes occur at the clock edge when `MemWrite`=1.
  - RAM contents are not affected by `rst`.
- **Peripheral window.** Offset is `addr[7:0]`.
  - 0x00 LED, read/write, bits [15:0]. Reads return the value zero-extended.
  - 0x04 SWITCH, read-only. Returns `sw_in` after a 2-flop synchronizer, zero-extended.
  - 0x08 TCOUNT, read/write, 32-bit timer count.
  - 0x0C TCMP, read/write, 32-bit compare value.
  - 0x10 TCTRL:
    - bit0 EN, read/write.
    - bit1 AUTO, read/write.
    - bit2 PEND, read / write-1-to-clear.
    - Other bits read 0.
  - 0x14 WRCNT, read-only. 32-bit count of RAM writes, wraps at 2^32.
  - Any other offset reads 0; writes to it are ignored.
- **Timer.**
  - When EN=1, each cycle: if TCOUNT==TCMP, then PEND←1 and TCOUNT←(AUTO ? 0 : TCOUNT+1). Otherwise TCOUNT←TCOUNT+1.
  - TCOUNT wraps at 2^32.
  - When EN=0, TCOUNT holds and no match is detected.
  - `timer_irq`=PEND, independent of EN.
- **Simultaneous events.**
  - A CPU write to TCOUNT overrides the increment or reload in that cycle.
  - A match sets PEND in the same cycle a write-1 tries to clear it; set wins.
  - A TCTRL write updates EN and AUTO at the edge. The match check in that cycle uses the old EN.
  - Writes to read-only offsets do not change any state.
- **Reset values.**
  - LED=0, TCOUNT=0, TCMP=32'hFFFF_FFFF, EN=AUTO=PEND=0, WRCNT=0, synchronizer flops=0.
  - Outputs: `led_out`=0, `timer_irq`=0.
  - `readdata` reflects these values combinationally.
- **Reset during operation.** Asserting `rst` at any time clears all registers immediately. No write is performed while `rst`=1.

## Timing
- **Load latency.** 0 cycles: `readdata` is valid in the same cycle `addr` is stable.
- **Store.** Takes effect at the first rising edge with `MemWrite`=1.
- **Load after store.** A load in the following cycle returns the new data. A load in the same cycle as a store to the same address returns the old data.
- **SWITCH.** A change on `sw_in` is visible at offset 0x04 two edges later.
- **PEND and `timer_irq`.** Both rise on the edge at which TCOUNT==TCMP with EN=1.
- **Auto-reload period.** With AUTO=1 and TCMP=N, the timer period is N+1 cycles.
- **WRCNT.** Increments on the same edge as the RAM write.

## Test plan
- **RAM store/load.** Store 0xDEADBEEF to 0x00000010, then load 0x00000010 and 0x00000013 on the next cycle → both return 0xDEADBEEF. WRCNT=1.
- **RAM wrap.** With DEPTH_WORDS=1024, store 0x12345678 to 0x00001010 → a load from 0x00000010 returns 0x12345678.
- **LED and SWITCH.** Store 0x0001A5A5 to 0xFFFF0000 → `led_out`=0xA5A5 and a readback returns 0x0000A5A5. Drive `sw_in`=0x00FF → a load from 0xFFFF0004 returns 0x000000FF after 2 edges and returns the old value before that.
- **Timer one-shot.** Write TCMP=5, TCOUNT=0, TCTRL=1 → `timer_irq` rises on the 6th edge after the TCTRL write; TCOUNT continues to 6, 7, and so on. Write TCTRL=0x5 → PEND clears and EN stays 1.
- **Auto-reload and collision.**
  - Write TCMP=3 and TCTRL=3 → PEND sets every 4 cycles and TCOUNT goes 0→3→0.
  - A write-1 to PEND on a match edge leaves PEND=1.
  - A write of TCOUNT=100 on a match edge loads 100.
- **Reset mid-operation.** Assert `rst` asynchronously while the timer runs with PEND=1 → `timer_irq`, `led_out`, TCOUNT and WRCNT read 0 immediately, and TCMP reads 0xFFFFFFFF. RAM data written before reset is still readable after reset.
